// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit CPU data port to 16-bit asynchronous SRAM bridge
//
// Each 32-bit access runs as two 16-bit SRAM phases (LOW = bits 15:0,
// HIGH = bits 31:16), each WAIT_CYCLES long, followed by one DONE cycle.
// ready stays low while an access is in flight so the CPU pipeline freezes.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   rd_en, wr_en        MEM-stage load/store request (both high = store)
//   address             CPU byte address, word aligned, offset by MEM_BASE
//   write_data          store data
//   read_data           registered load data, updated atomically at end of HIGH
//   ready               1 = no access pending or access completing
//   sram_addr           SRAM halfword address {word, phase}
//   sram_dq_out         data driven to SRAM
//   sram_dq_in          data returned by SRAM
//   sram_dq_oe          1 = controller drives the DQ bus
//   sram_we_n           active-low SRAM write strobe
module sram_controller #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] MEM_BASE    = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [16:0] word_q, word_d;
    logic [31:0] data_q, data_d;
    logic [15:0] low_q, low_d;
    logic [31:0] read_data_q, read_data_d;

    // Byte offset into SRAM; only bits 18:2 form the word index, so
    // addresses beyond 2^17 words wrap.
    logic [31:0] offset;
    logic        unused_offset_bits;

    assign offset             = address - MEM_BASE;
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
    assign read_data          = read_data_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        word_d      = word_q;
        data_d      = data_q;
        low_d       = low_q;
        read_data_d = read_data_q;
        ready       = 1'b0;
        sram_addr   = 18'd0;
        sram_dq_out = 16'd0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;

        case (state_q)
            IDLE: begin
                ready = ~(rd_en | wr_en);
                if (rd_en | wr_en) begin
                    state_d = LOW;
                    cnt_d   = 4'd0;
                    is_wr_d = wr_en;
                    word_d  = offset[18:2];
                    data_d  = write_data;
                end
            end
            LOW: begin
                sram_addr = {word_q, 1'b0};
                if (is_wr_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                    sram_dq_out = data_q[15:0];
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 4'd0;
                    state_d = HIGH;
                    if (!is_wr_q) begin
                        low_d = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HIGH: begin
                sram_addr = {word_q, 1'b1};
                if (is_wr_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                    sram_dq_out = data_q[31:16];
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 4'd0;
                    state_d = DONE;
                    // Both halves land together so read_data never shows a mix.
                    if (!is_wr_q) begin
                        read_data_d = {sram_dq_in, low_q};
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            is_wr_q     <= 1'b0;
            word_q      <= 17'd0;
            data_q      <= 32'd0;
            low_q       <= 16'd0;
            read_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            word_q      <= word_d;
            data_q      <= data_d;
            low_q       <= low_d;
            read_data_q <= read_data_d;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller
module tb_sram_controller;

    localparam int          W    = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in = 16'd0;
    logic        sram_dq_oe;
    logic        sram_we_n;

    sram_controller #(
        .WAIT_CYCLES(W),
        .MEM_BASE   (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] sram_mem [0:1023];
    logic [31:0] model    [0:255];
    logic [33:0] exp_wr_q [$];
    logic [31:0] exp_rd_q [$];
    logic [31:0] last_rd = 32'd0;
    logic [33:0] mon_e;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] wi(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return o[18:2];
    endfunction

    // Halfword SRAM: write on strobe, read data presented mid-cycle.
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr[9:0]] <= sram_dq_out;
    end
    always @(negedge clk) sram_dq_in = sram_mem[sram_addr[9:0]];

    // Every write-strobe cycle must match the next expected halfword write.
    always @(negedge clk) begin
        if (rst && !sram_we_n) begin
            if (exp_wr_q.size() == 0) begin
                check_val("wr_unexpected", 32'(sram_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_wr_q.pop_front();
                check_val("wr_addr", 32'(sram_addr), 32'(mon_e[33:16]));
                check_val("wr_data", 32'(sram_dq_out), 32'(mon_e[15:0]));
            end
        end
    end

    // Drives one access starting in an IDLE cycle; mid-access inputs change to
    // the *2 values, and the request is dropped at DONE unless hold is set.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic rd2, input logic wr2, input logic [31:0] a2, input logic [31:0] d2,
                             input bit hold);
        logic [16:0] w;
        logic [31:0] e;
        logic        ph;
        @(negedge clk);
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        w = wi(a);
        if (wr) begin
            model[w[7:0]] = d;
            for (int k = 0; k < W; k++) exp_wr_q.push_back({w, 1'b0, d[15:0]});
            for (int k = 0; k < W; k++) exp_wr_q.push_back({w, 1'b1, d[31:16]});
            exp_rd_q.push_back(last_rd);
        end else begin
            last_rd = model[w[7:0]];
            exp_rd_q.push_back(last_rd);
        end
        #1 check_val("ready_c0", 32'(ready), 32'd0);
        for (int k = 1; k <= 2 * W + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rd_en = rd2; wr_en = wr2; address = a2; write_data = d2;
            end
            #1;
            if (k <= 2 * W) begin
                ph = (k > W);
                check_val("ready_busy", 32'(ready), 32'd0);
                check_val("addr", 32'(sram_addr), 32'({w, ph}));
                check_val("dq_oe", 32'(sram_dq_oe), 32'(wr));
                check_val("we_n", 32'(sram_we_n), 32'(!wr));
            end else begin
                check_val("ready_done", 32'(ready), 32'd1);
                e = exp_rd_q.pop_front();
                check_val("read_data", read_data, e);
                if (!hold) begin
                    rd_en = 1'b0; wr_en = 1'b0;
                end
            end
        end
    endtask

    task automatic std_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        do_access(rd, wr, a, d, rd, wr, a ^ 32'h40, ~d, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sram_mem[i] = 16'd0;
        for (int i = 0; i < 256; i++) model[i] = 32'd0;
        sram_mem[4] = 16'h1234;
        sram_mem[5] = 16'h5678;
        model[2]    = 32'h5678_1234;

        repeat (3) @(negedge clk);
        #1;
        check_val("rst_we_n", 32'(sram_we_n), 32'd1);
        check_val("rst_oe", 32'(sram_dq_oe), 32'd0);
        check_val("rst_addr", 32'(sram_addr), 32'd0);
        check_val("rst_dq_out", 32'(sram_dq_out), 32'd0);
        check_val("rst_read_data", read_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check_val("ready_idle", 32'(ready), 32'd1);

        std_access(1'b0, 1'b1, BASE, 32'hDEAD_BEEF);
        std_access(1'b1, 1'b0, BASE + 32'd8, 32'h0);
        std_access(1'b1, 1'b0, BASE, 32'h0);
        std_access(1'b1, 1'b1, BASE + 32'd16, 32'hCAFE_F00D);
        std_access(1'b1, 1'b0, BASE + 32'd16, 32'h0);
        std_access(1'b0, 1'b1, BASE + 32'd4 * 32'h2_0000, 32'h0BAD_F00D);
        std_access(1'b1, 1'b0, BASE, 32'h0);

        // Back-to-back: request held through DONE; the second is a read of the first's data.
        do_access(1'b0, 1'b1, BASE + 32'd24, 32'h1111_2222,
                  1'b1, 1'b0, BASE + 32'd24, 32'h0, 1'b1);
        std_access(1'b1, 1'b0, BASE + 32'd24, 32'h0);

        // Reset during the HIGH phase of a write.
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b1; address = BASE + 32'd32; write_data = 32'hA5A5_5A5A;
        for (int k = 0; k < W; k++) exp_wr_q.push_back({wi(address), 1'b0, write_data[15:0]});
        for (int k = 0; k < W; k++) exp_wr_q.push_back({wi(address), 1'b1, write_data[31:16]});
        repeat (W + 1) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_val("abort_we_n", 32'(sram_we_n), 32'd1);
        check_val("abort_oe", 32'(sram_dq_oe), 32'd0);
        check_val("abort_addr", 32'(sram_addr), 32'd0);
        check_val("abort_dq_out", 32'(sram_dq_out), 32'd0);
        check_val("abort_read_data", read_data, 32'd0);
        exp_wr_q.delete();
        wr_en = 1'b0;
        last_rd = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("post_rst_ready", 32'(ready), 32'd1);
        @(negedge clk);
        #1 check_val("post_rst_addr", 32'(sram_addr), 32'd0);

        std_access(1'b1, 1'b0, BASE, 32'h0);

        repeat (2) @(negedge clk);
        check_val("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
